msx2_mapper_mem_port: RTL



---
 rtl/msx2_mapper_mem_port_pkg.sv | 22 ++
 rtl/msx2_mapper_regs.sv | 77 +++++++
 rtl/msx2_mapper_mem_port.sv | 135 +++++++++++++
 3 files changed

// File: rtl/msx2_mapper_mem_port_pkg.sv
// Shared MSX mapper definitions: port decode base, FSM state type and
// the power-on page layout of the internal memory mapper.
package msx2_mapper_mem_port_pkg;

  // Mapper page registers live at I/O ports FC..FF.
  localparam logic [7:0] MAPPER_PORT_BASE = 8'hFC;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mapper_state_t;

  // Power-on contents indexed by page register: page 0 = 3 ... page 3 = 0,
  // so the lowest 64 KB of RAM appears in reverse order at reset.
  localparam logic [3:0][7:0] MAPPER_RESET_PAGES = {8'd0, 8'd1, 8'd2, 8'd3};

  // True when an I/O port number addresses one of the four page registers.
  function automatic logic is_mapper_port(input logic [7:0] port);
    return port[7:2] == MAPPER_PORT_BASE[7:2];
  endfunction

endpackage

// File: rtl/msx2_mapper_regs.sv
// Mapper page registers: I/O port decode, register file, readback
// formatting and limit masking of the page used for translation.
module msx2_mapper_regs
  import msx2_mapper_mem_port_pkg::*;
#(
  parameter int PAGE_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_wr,
  input  logic                 io_rd,
  input  logic [7:0]           io_addr,
  input  logic [7:0]           io_din,
  input  logic                 limit_internal_mapper,
  input  logic [1:0]           page_sel,
  output logic [PAGE_BITS-1:0] page_out,
  output logic [7:0]           io_dout,
  output logic                 io_dout_valid
);

  logic [PAGE_BITS-1:0] r_page [4];
  logic [7:0]           r_io_dout;
  logic                 r_io_dout_valid;
  logic                 w_hit;
  logic [7:0]           w_rd_fmt;
  logic [PAGE_BITS-1:0] w_page_raw;

  assign w_hit      = is_mapper_port(io_addr);
  assign w_page_raw = r_page[page_sel];

  // Page registers: the full value is stored; the limit only applies on use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_page[i] <= MAPPER_RESET_PAGES[i][PAGE_BITS-1:0];
      end
    end else if (io_wr && w_hit) begin
      r_page[io_addr[1:0]] <= io_din[PAGE_BITS-1:0];
    end
  end

  // Readback format: unimplemented high bits read as 1; when limited only
  // the two low bits are meaningful.
  always_comb begin
    w_rd_fmt = 8'hFF;
    w_rd_fmt[PAGE_BITS-1:0] = r_page[io_addr[1:0]];
    if (limit_internal_mapper) begin
      w_rd_fmt[7:2] = 6'h3F;
    end
  end

  // Translation page: restricted to the first four pages when limited.
  always_comb begin
    page_out = w_page_raw;
    if (limit_internal_mapper) begin
      page_out      = '0;
      page_out[1:0] = w_page_raw[1:0];
    end
  end

  // Readback register: one-cycle latency, holds its value on a miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_io_dout       <= 8'hFF;
      r_io_dout_valid <= 1'b0;
    end else begin
      r_io_dout_valid <= io_rd && w_hit;
      if (io_rd && w_hit) begin
        r_io_dout <= w_rd_fmt;
      end
    end
  end

  assign io_dout       = r_io_dout;
  assign io_dout_valid = r_io_dout_valid;

endmodule

// File: rtl/msx2_mapper_mem_port.sv
// Memory side of the MSX2 internal RAM mapper: translates CPU memory cycles
// in the mapper slot into linear RAM addresses and runs the RAM handshake.
//
// RAM handshake: ram_req is a level held from the cycle after accept until
// the cycle after ram_ack. ram_addr/ram_we/ram_wdata are latched at accept
// and stay stable while ram_req is high. ram_ack is a one-cycle pulse that
// is only honoured while ram_req is high; ram_rdata is valid with it.
module msx2_mapper_mem_port
  import msx2_mapper_mem_port_pkg::*;
#(
  parameter int PAGE_BITS  = 8,
  parameter int ADDR_WIDTH = 14 + PAGE_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_wr,
  input  logic                  io_rd,
  input  logic [7:0]            io_addr,
  input  logic [7:0]            io_din,
  output logic [7:0]            io_dout,
  output logic                  io_dout_valid,
  input  logic                  limit_internal_mapper,
  input  logic                  mem_rq,
  input  logic                  mem_sel,
  input  logic                  mem_wr,
  input  logic [15:0]           mem_addr,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic                  mem_dout_valid,
  output logic                  cpu_wait,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic                  ram_ack,
  input  logic [7:0]            ram_rdata,
  output mapper_state_t         dbg_state
);

  mapper_state_t         r_state;
  mapper_state_t         w_state_next;
  logic                  w_accept;
  logic [PAGE_BITS-1:0]  w_page;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_ram_we;
  logic [7:0]            r_ram_wdata;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_dout_valid;

  msx2_mapper_regs #(
    .PAGE_BITS (PAGE_BITS)
  ) u_regs (
    .clk                   (clk),
    .reset                 (reset),
    .io_wr                 (io_wr),
    .io_rd                 (io_rd),
    .io_addr               (io_addr),
    .io_din                (io_din),
    .limit_internal_mapper (limit_internal_mapper),
    .page_sel              (mem_addr[15:14]),
    .page_out              (w_page),
    .io_dout               (io_dout),
    .io_dout_valid         (io_dout_valid)
  );

  assign w_accept = (r_state == IDLE) && mem_rq && mem_sel;

  // State register; reset drops ram_req immediately since it decodes state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    ram_req      = 1'b0;
    cpu_wait     = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_wait = w_accept;
        if (w_accept) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        ram_req  = 1'b1;
        cpu_wait = 1'b1;
        if (ram_ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Access latch: the page register value at accept is frozen here, so
  // later page writes cannot disturb a pending access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= 8'h00;
    end else if (w_accept) begin
      r_ram_addr  <= ADDR_WIDTH'({w_page, mem_addr[13:0]});
      r_ram_we    <= mem_wr;
      r_ram_wdata <= mem_din;
    end
  end

  // Read data capture and its one-cycle valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_dout       <= 8'hFF;
      r_mem_dout_valid <= 1'b0;
    end else begin
      r_mem_dout_valid <= 1'b0;
      if ((r_state == REQ) && ram_ack && !r_ram_we) begin
        r_mem_dout       <= ram_rdata;
        r_mem_dout_valid <= 1'b1;
      end
    end
  end

  assign ram_addr       = r_ram_addr;
  assign ram_we         = r_ram_we && ram_req;
  assign ram_wdata      = r_ram_wdata;
  assign mem_dout       = r_mem_dout;
  assign mem_dout_valid = r_mem_dout_valid;
  assign dbg_state      = r_state;

endmodule
